// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_if
// Description : Request / ALU / response bundle between the control unit,
//               the issue controller and the 16-bit ALU.
//               master = requester/consumer side, slave = issue controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 3
);
    // Request channel
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_fn;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [TAG_W-1:0] req_tag;

    // ALU operand/result bus
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_r;

    // Response channel
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic             rsp_ovfl;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_fn, req_a, req_b, req_tag,
        input  req_ready,
        input  alu_a, alu_b, alu_op,
        output alu_r,
        input  rsp_valid, rsp_data, rsp_zero, rsp_ovfl, rsp_err, rsp_tag,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_fn, req_a, req_b, req_tag,
        output req_ready,
        output alu_a, alu_b, alu_op,
        input  alu_r,
        output rsp_valid, rsp_data, rsp_zero, rsp_ovfl, rsp_err, rsp_tag,
        input  rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Issues one function request at a time to the datapath ALU,
//               holds its operands for a single execute cycle, captures the
//               result and returns it with locally computed zero / signed
//               overflow / illegal-function flags.
//               Optional feature macro: ALU_ISSUE_OVFL_TRAP_EN adds a sticky
//               overflow trap (rsp_trap / trap_clr) that blocks new requests.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus,
    output logic        busy
`ifdef ALU_ISSUE_OVFL_TRAP_EN
    ,
    output logic        rsp_trap,
    input  logic        trap_clr
`endif
);

    // Request function codes
    localparam logic [2:0] c_FN_AND  = 3'b000;
    localparam logic [2:0] c_FN_OR   = 3'b001;
    localparam logic [2:0] c_FN_NOR  = 3'b010;
    localparam logic [2:0] c_FN_ADD  = 3'b011;
    localparam logic [2:0] c_FN_SUB  = 3'b100;
    localparam logic [2:0] c_FN_SLT  = 3'b101;
    localparam logic [2:0] c_FN_PASS = 3'b110;
    localparam logic [2:0] c_FN_ILL  = 3'b111;

    // ALU op codes
    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_NOR = 4'b0010;
    localparam logic [3:0] c_OP_ADD = 4'b0011;
    localparam logic [3:0] c_OP_SUB = 4'b0100;
    localparam logic [3:0] c_OP_SLT = 4'b0101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic [2:0]       fn_q;
    logic [TAG_W-1:0] tag_q;
    logic [WIDTH-1:0] alu_a_q, alu_b_q;
    logic [3:0]       alu_op_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_zero_q, rsp_ovfl_q, rsp_err_q;
    logic [TAG_W-1:0] rsp_tag_q;

    logic [WIDTH-1:0] alu_a_d, alu_b_d;
    logic [3:0]       alu_op_d;
    logic [WIDTH-1:0] rsp_data_d;
    logic             rsp_zero_d, rsp_ovfl_d, rsp_err_d;
    logic             trap_block;

    // Translate the incoming function into ALU operands/op; pass-a rides on
    // add with b forced to zero, illegal issues a harmless all-zero AND.
    always_comb begin
        alu_op_d = c_OP_AND;
        alu_a_d  = bus.req_a;
        alu_b_d  = bus.req_b;
        case (bus.req_fn)
            c_FN_AND:  alu_op_d = c_OP_AND;
            c_FN_OR:   alu_op_d = c_OP_OR;
            c_FN_NOR:  alu_op_d = c_OP_NOR;
            c_FN_ADD:  alu_op_d = c_OP_ADD;
            c_FN_SUB:  alu_op_d = c_OP_SUB;
            c_FN_SLT:  alu_op_d = c_OP_SLT;
            c_FN_PASS: begin
                alu_op_d = c_OP_ADD;
                alu_b_d  = '0;
            end
            default: begin
                alu_op_d = c_OP_AND;
                alu_a_d  = '0;
                alu_b_d  = '0;
            end
        endcase
    end

    // Result capture and flag generation from the held operands' sign bits.
    always_comb begin
        rsp_err_d  = (fn_q == c_FN_ILL);
        rsp_data_d = rsp_err_d ? '0 : bus.alu_r;
        rsp_zero_d = !rsp_err_d && (bus.alu_r == '0);
        rsp_ovfl_d = 1'b0;
        case (fn_q)
            c_FN_ADD: rsp_ovfl_d = (alu_a_q[WIDTH-1] == alu_b_q[WIDTH-1]) &&
                                   (bus.alu_r[WIDTH-1] != alu_a_q[WIDTH-1]);
            c_FN_SUB: rsp_ovfl_d = (alu_a_q[WIDTH-1] != alu_b_q[WIDTH-1]) &&
                                   (bus.alu_r[WIDTH-1] != alu_a_q[WIDTH-1]);
            default:  rsp_ovfl_d = 1'b0;
        endcase
    end

`ifdef ALU_ISSUE_OVFL_TRAP_EN
    logic trap_q;

    // Sticky overflow trap: set at the capture edge, cleared by trap_clr;
    // a set in the same cycle as a clear wins so no overflow is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_q <= 1'b0;
        end else if (state_q == S_EXEC && rsp_ovfl_d) begin
            trap_q <= 1'b1;
        end else if (trap_clr) begin
            trap_q <= 1'b0;
        end
    end

    assign trap_block = trap_q;
    assign rsp_trap   = trap_q;
`else
    assign trap_block = 1'b0;
`endif

    // Issue FSM: IDLE accepts, EXEC drives the ALU for one cycle, RESP holds
    // the response until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fn_q        <= '0;
            tag_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_ovfl_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_tag_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid && !trap_block) begin
                        fn_q     <= bus.req_fn;
                        tag_q    <= bus.req_tag;
                        alu_a_q  <= alu_a_d;
                        alu_b_q  <= alu_b_d;
                        alu_op_q <= alu_op_d;
                        state_q  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_data_q  <= rsp_data_d;
                    rsp_zero_q  <= rsp_zero_d;
                    rsp_ovfl_q  <= rsp_ovfl_d;
                    rsp_err_q   <= rsp_err_d;
                    rsp_tag_q   <= tag_q;
                    rsp_valid_q <= 1'b1;
                    alu_a_q     <= '0;
                    alu_b_q     <= '0;
                    alu_op_q    <= '0;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = (state_q == S_IDLE) && !trap_block;
    assign busy          = (state_q != S_IDLE);
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_ovfl  = rsp_ovfl_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_tag   = rsp_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Self-checking bench for alu_issue_ctrl with a behavioural ALU
//               and an arithmetic reference model of the response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;
    localparam int WIDTH = 16;
    localparam int TAG_W = 3;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_issue_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

`ifdef ALU_ISSUE_OVFL_TRAP_EN
    logic rsp_trap;
    logic trap_clr;
`endif

    alu_issue_ctrl #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy)
`ifdef ALU_ISSUE_OVFL_TRAP_EN
        ,
        .rsp_trap (rsp_trap),
        .trap_clr (trap_clr)
`endif
    );

    // Behavioural datapath ALU
    always_comb begin
        case (bus.alu_op)
            4'd0:    bus.alu_r = bus.alu_a & bus.alu_b;
            4'd1:    bus.alu_r = bus.alu_a | bus.alu_b;
            4'd2:    bus.alu_r = ~(bus.alu_a | bus.alu_b);
            4'd3:    bus.alu_r = bus.alu_a + bus.alu_b;
            4'd4:    bus.alu_r = bus.alu_a - bus.alu_b;
            4'd5:    bus.alu_r = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 16'd1 : 16'd0;
            default: bus.alu_r = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: response computed with integer arithmetic from the function
    function automatic void model(input logic [2:0] fn, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] d, output logic z, output logic o,
                                  output logic e);
        int sa, sb, s;
        sa = $signed(a);
        sb = $signed(b);
        s  = 0;
        o  = 1'b0;
        e  = 1'b0;
        case (fn)
            3'd0: d = a & b;
            3'd1: d = a | b;
            3'd2: d = ~(a | b);
            3'd3: begin s = sa + sb; d = s[15:0]; o = (s > 32767) || (s < -32768); end
            3'd4: begin s = sa - sb; d = s[15:0]; o = (s > 32767) || (s < -32768); end
            3'd5: d = (sa < sb) ? 16'd1 : 16'd0;
            3'd6: d = a;
            default: begin d = 16'd0; e = 1'b1; end
        endcase
        z = !e && (d == 16'd0);
    endfunction

    function automatic logic [3:0] exp_op(input logic [2:0] fn);
        case (fn)
            3'd0: return 4'b0000;
            3'd1: return 4'b0001;
            3'd2: return 4'b0010;
            3'd3: return 4'b0011;
            3'd4: return 4'b0100;
            3'd5: return 4'b0101;
            3'd6: return 4'b0011;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 20) begin
            tick();
            n++;
        end
        chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    endtask

    task automatic txn(input logic [2:0] fn, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] tag, input int hold);
        logic [15:0] d;
        logic z, o, e;
        model(fn, a, b, d, z, o, e);
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_fn    = fn;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        tick();
        bus.req_valid = 1'b0;
        bus.req_a     = 16'($urandom);
        bus.req_b     = 16'($urandom);
        // EXEC cycle
        chk("exec_busy", {31'd0, busy}, 32'd1);
        chk("exec_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("exec_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("exec_alu_op", {28'd0, bus.alu_op}, {28'd0, exp_op(fn)});
        chk("exec_alu_a", {16'd0, bus.alu_a}, (fn == 3'd7) ? 32'd0 : {16'd0, a});
        chk("exec_alu_b", {16'd0, bus.alu_b}, (fn >= 3'd6) ? 32'd0 : {16'd0, b});
        tick();
        // RESP, held for 'hold' extra cycles
        for (int i = 0; i <= hold; i++) begin
            chk("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("rsp_data", {16'd0, bus.rsp_data}, {16'd0, d});
            chk("rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, z});
            chk("rsp_ovfl", {31'd0, bus.rsp_ovfl}, {31'd0, o});
            chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e});
            chk("rsp_tag", {29'd0, bus.rsp_tag}, {29'd0, tag});
            chk("rsp_alu_op_idle", {28'd0, bus.alu_op}, 32'd0);
            if (i < hold) tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("post_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("post_busy", {31'd0, busy}, 32'd0);
`ifdef ALU_ISSUE_OVFL_TRAP_EN
        chk("trap_set", {31'd0, rsp_trap}, {31'd0, o});
        if (o) begin
            chk("trap_blocks_ready", {31'd0, bus.req_ready}, 32'd0);
            tick();
            chk("trap_still_blocks", {31'd0, bus.req_ready}, 32'd0);
            trap_clr = 1'b1;
            tick();
            trap_clr = 1'b0;
            chk("trap_cleared", {31'd0, rsp_trap}, 32'd0);
        end
`endif
        chk("post_req_ready", {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] hold_data;
        logic [15:0] ra, rb;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_fn    = 3'd0;
        bus.req_a     = 16'd0;
        bus.req_b     = 16'd0;
        bus.req_tag   = 3'd0;
        bus.rsp_ready = 1'b0;
`ifdef ALU_ISSUE_OVFL_TRAP_EN
        trap_clr = 1'b0;
`endif
        tick();
        tick();

        // Reset state
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_data", {16'd0, bus.rsp_data}, 32'd0);
        chk("rst_flags", {29'd0, bus.rsp_zero, bus.rsp_ovfl, bus.rsp_err}, 32'd0);
        chk("rst_rsp_tag", {29'd0, bus.rsp_tag}, 32'd0);
        chk("rst_alu", {bus.alu_a ^ bus.alu_b, 12'd0, bus.alu_op}, 32'd0);
        chk("rst_alu_a", {16'd0, bus.alu_a}, 32'd0);
`ifdef ALU_ISSUE_OVFL_TRAP_EN
        chk("rst_trap", {31'd0, rsp_trap}, 32'd0);
`endif
        rst = 1'b0;
        tick();

        // Directed boundary cases
        txn(3'd3, 16'h0003, 16'h0004, 3'd5, 0);
        txn(3'd4, 16'h8000, 16'h0001, 3'd1, 0);
        txn(3'd3, 16'h7FFF, 16'h0001, 3'd2, 2);
        txn(3'd0, 16'h00F0, 16'h0F00, 3'd3, 0);
        txn(3'd7, 16'h1234, 16'h5678, 3'd4, 1);
        txn(3'd6, 16'hA5A5, 16'h5A5A, 3'd6, 0);
        txn(3'd5, 16'hFFFF, 16'h0001, 3'd7, 0);
        txn(3'd2, 16'h0F0F, 16'h00FF, 3'd0, 0);

        // Back-pressure with req_valid held high: no second accept
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_fn    = 3'd3;
        bus.req_a     = 16'h0001;
        bus.req_b     = 16'h0002;
        bus.req_tag   = 3'd6;
        tick();
        tick();
        hold_data = 16'h0003;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
            chk("bp_rsp_data", {16'd0, bus.rsp_data}, {16'd0, hold_data});
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        chk("bp_release_busy", {31'd0, busy}, 32'd0);
        chk("bp_release_valid", {31'd0, bus.rsp_valid}, 32'd0);
        tick();
        chk("bp_no_reaccept", {31'd0, busy}, 32'd0);

        // Reset while in EXEC drops the request
        bus.req_valid = 1'b1;
        bus.req_fn    = 3'd3;
        bus.req_a     = 16'h0005;
        bus.req_b     = 16'h0006;
        tick();
        bus.req_valid = 1'b0;
        chk("rx_exec_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        chk("rx_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rx_busy", {31'd0, busy}, 32'd0);
        chk("rx_alu_op", {28'd0, bus.alu_op}, 32'd0);
        chk("rx_rsp_data", {16'd0, bus.rsp_data}, 32'd0);
        rst = 1'b0;
        tick();
        tick();
        chk("rx_no_response", {31'd0, bus.rsp_valid}, 32'd0);

        // Randomized traffic with sign-boundary operands mixed in
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0:       ra = 16'h7FFF;
                1:       ra = 16'h8000;
                default: ra = 16'($urandom);
            endcase
            rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            txn(3'($urandom_range(0, 7)), ra, rb, 3'($urandom), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Initiator-side controller for the 16-bit datapath ALU. Accepts one function request at a time over a valid/ready handshake, registers the operands, drives the ALU's `a`/`b`/`op` inputs for one execute cycle, captures the result, and returns it with locally computed zero/overflow flags over a second valid/ready handshake. It sits between the multi-cycle control unit and the ALU, replacing direct op-code wiring from control.

## Interface

Parameters:
- `WIDTH`, 16, datapath width; ALU op encoding is fixed at 4 bits.
- `TAG_W`, 3, width of the request tag echoed on the response.

Ports:
- `clk`  in  1  the single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_fn`  in  3  function: 000 and, 001 or, 010 nor, 011 add, 100 sub, 101 slt, 110 pass-a, 111 illegal.
- `req_a`, `req_b`  in  WIDTH  signed operands.
- `req_tag`  in  TAG_W  opaque tag.
- `alu_a`, `alu_b`  out  WIDTH  ALU operands.
- `alu_op`  out  4  ALU op code.
- `alu_r`  in  WIDTH  ALU result (combinational from `alu_a`/`alu_b`/`alu_op`).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  WIDTH  captured result.
- `rsp_zero`, `rsp_ovfl`, `rsp_err`  out  1  result==0, signed overflow, illegal function.
- `rsp_tag`  out  TAG_W  echoed tag.
- `busy`  out  1  state != IDLE.
- `rsp_trap`, `trap_clr`  out/in  1  present only with `ALU_ISSUE_OVFL_TRAP_EN`.

## Operation

- FSM states: IDLE, EXEC, RESP.
- IDLE: `req_ready`=1. On `req_valid`&&`req_ready` at an edge: latch `req_a`, `req_b`, `req_fn`, `req_tag`; go to EXEC.
- EXEC: `alu_a`/`alu_b`/`alu_op` driven from latched values; at the edge capture `alu_r` into `rsp_data`, compute flags, go to RESP.
- RESP: `rsp_valid`=1, all `rsp_*` stable; on `rsp_ready` at an edge go to IDLE. No request is accepted outside IDLE (no bypass).
- fn→op mapping: and 0000, or 0001, nor 0010, add 0011, sub 0100, slt 0101, pass-a 0011 with `alu_b` forced 0.
- Illegal (111): EXEC still occurs with `alu_op`=0000 and `alu_a`=`alu_b`=0; response has `rsp_err`=1, `rsp_data`=0, `rsp_zero`=0, `rsp_ovfl`=0.
- `rsp_zero` = (captured result == 0), computed locally; no ALU zero flag is used.
- `rsp_ovfl` computed locally from sign bits: add → a15==b15 && r15!=a15; sub → a15!=b15 && r15!=a15; all other functions 0.
- Outside EXEC: `alu_a`=`alu_b`=0, `alu_op`=0000.

## Timing

- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `busy`=0, `rsp_data`=0, all flags 0, `rsp_tag`=0, ALU outputs 0, `rsp_trap`=0.
- Request accepted at edge k → EXEC during cycle k..k+1 → `rsp_valid` high after edge k+1 (latency 2 edges).
- Minimum issue interval is 3 cycles when `rsp_ready` is held high.
- `rsp_ready` low holds RESP indefinitely with outputs frozen.
- `rst` in any state (including EXEC or RESP): next edge returns to reset values; the in-flight request is dropped with no response.
- `req_valid` is ignored while `req_ready`=0.

## Configuration

- `ALU_ISSUE_OVFL_TRAP_EN` defined:
  - `rsp_ovfl`=1 on a response also sets sticky `rsp_trap` at the capture edge.
  - While `rsp_trap`=1, `req_ready`=0 even in IDLE.
  - A `trap_clr` pulse clears `rsp_trap` at the next edge; `rst` also clears it.
- Undefined:
  - `rsp_trap` and `trap_clr` ports are absent.
  - Overflow is reported only via `rsp_ovfl`, with no blocking.

## Test plan

- Reset, then add a=0x0003 b=0x0004 tag=5 → `rsp_valid` 2 edges after accept, `rsp_data`=0x0007, zero=0, ovfl=0, `rsp_tag`=5.
- sub a=0x8000 b=0x0001 → `rsp_data`=0x7FFF, `rsp_ovfl`=1; with macro `rsp_trap`=1 and `req_ready` stays 0 until `trap_clr`.
- add a=0x7FFF b=0x0001 → 0x8000, ovfl=1; and a=0x00F0 b=0x0F00 → 0x0000, zero=1, ovfl=0.
- `req_fn`=111 → `alu_op`=0000 during EXEC, `rsp_err`=1, `rsp_data`=0.
- Hold `rsp_ready`=0 for 5 cycles with `req_valid` high → response frozen, `req_ready`=0, no second accept; release → back to IDLE the next edge.
- Assert `rst` during EXEC → next cycle `rsp_valid`=0, `busy`=0, no response emitted.
